audio_voice_mixer: RTL and testbench

Time-multiplexed mixer that sums the team's sound-generator voices into one saturated 16-bit sample for the audio codec DAC path. Examples of voices are LFSR noise bursts and DDS tones. Each voice has its own gain and mute control. The block sits directly upstream of the codec DAC serializer's left/right data inputs. It starts one mix per rising edge of the DAC LR clock and produces one registered sample with a valid pulse.

---
 rtl/audio_mix_pkg.sv | 26 ++
 rtl/lrck_edge_sync.sv | 31 +++
 rtl/audio_voice_mixer.sv | 158 +++++++++++++++
 tb/tb_audio_voice_mixer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// Shared constants, FSM state type and width helper for the voice mixer.
package audio_mix_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 7;

  // Signed sample times zero-extended gain (GAIN_W + 1 bits).
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } mix_state_e;

  // Adding one growth bit per doubling of voice count keeps the running
  // sum from wrapping before the clamp stage.
  function automatic int acc_width(input int num_voices);
    return PROD_W + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/lrck_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous codec
// clock. oRISE is high for one iCLK cycle per rising edge of iASYNC.
module lrck_edge_sync (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iASYNC,
  output logic oSYNC,
  output logic oRISE
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer chain followed by the edge-history register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= iASYNC;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign oSYNC = sync2;
  assign oRISE = sync2 & ~prev;

endmodule

// File: rtl/audio_voice_mixer.sv
// Time-multiplexed voice mixer: on each LRCK rising edge it snapshots all
// voices, accumulates gain-weighted samples through one shared multiplier,
// then floors, clamps and registers a single 16-bit sample with a valid pulse.
//
// Handshake: oVALID is a one-cycle pulse with no ready; oMIX is valid while
// oVALID is high and holds its value until the next pulse.
module audio_voice_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                           iCLK,
  input  logic                           iRST_N,
  input  logic                           iLRCK,
  input  logic [SAMPLE_W*NUM_VOICES-1:0] iVOICE,
  input  logic [GAIN_W*NUM_VOICES-1:0]   iGAIN,
  input  logic [NUM_VOICES-1:0]          iMUTE,
  input  logic                           iCLIP_CLR,
  output logic [SAMPLE_W-1:0]            oMIX,
  output logic                           oVALID,
  output logic                           oCLIP,
  output logic                           oOVERRUN,
  output logic [1:0]                     oDBG_STATE
);

  localparam int ACC_W = acc_width(NUM_VOICES);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int R_W   = ACC_W - GAIN_FRAC;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [R_W-1:0]   R_MAX    = R_W'(SAT_MAX);
  localparam logic signed [R_W-1:0]   R_MIN    = R_W'(SAT_MIN);

  mix_state_e state_q;
  mix_state_e state_d;

  logic                           lrck_sync;
  logic                           start;

  logic [SAMPLE_W*NUM_VOICES-1:0] voice_snap;
  logic [GAIN_W*NUM_VOICES-1:0]   gain_snap;
  logic [NUM_VOICES-1:0]          mute_snap;
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;

  logic signed [SAMPLE_W-1:0]     cur_voice;
  logic [GAIN_W-1:0]              cur_gain;
  logic                           cur_mute;
  logic signed [PROD_W-1:0]       product;
  logic signed [R_W-1:0]          shifted;
  logic signed [SAMPLE_W-1:0]     clamped;
  logic                           clip_hit;

  lrck_edge_sync u_lrck_sync (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iASYNC (iLRCK),
    .oSYNC  (lrck_sync),
    .oRISE  (start)
  );

  // Shared multiplier: select the current voice from the snapshot and weight it.
  always_comb begin
    cur_voice = voice_snap[idx*SAMPLE_W +: SAMPLE_W];
    cur_gain  = gain_snap[idx*GAIN_W +: GAIN_W];
    cur_mute  = mute_snap[idx];
    product   = '0;
    if (!cur_mute) begin
      product = cur_voice * $signed({1'b0, cur_gain});
    end
  end

  // Drop the fractional gain bits (arithmetic, floor) and clamp to 16 bits.
  always_comb begin
    shifted  = acc[ACC_W-1:GAIN_FRAC];
    clamped  = shifted[SAMPLE_W-1:0];
    clip_hit = 1'b0;
    if (shifted > R_MAX) begin
      clamped  = SAMPLE_W'(SAT_MAX);
      clip_hit = 1'b1;
    end else if (shifted < R_MIN) begin
      clamped  = SAMPLE_W'(SAT_MIN);
      clip_hit = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: wait for an LRCK edge, walk every voice, then saturate.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: snapshot, accumulate, publish result and maintain sticky flags.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      voice_snap <= '0;
      gain_snap  <= '0;
      mute_snap  <= '0;
      idx        <= '0;
      acc        <= '0;
      oMIX       <= '0;
      oVALID     <= 1'b0;
      oCLIP      <= 1'b0;
      oOVERRUN   <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            voice_snap <= iVOICE;
            gain_snap  <= iGAIN;
            mute_snap  <= iMUTE;
            acc        <= '0;
            idx        <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(product);
          idx <= idx + 1'b1;
        end
        SAT: begin
          oMIX   <= clamped;
          oVALID <= 1'b1;
        end
        default: ;
      endcase
      // Clear first so that a same-cycle set takes priority.
      if (iCLIP_CLR) begin
        oCLIP    <= 1'b0;
        oOVERRUN <= 1'b0;
      end
      if (state_q == SAT && clip_hit) begin
        oCLIP <= 1'b1;
      end
      // An edge during a mix is dropped; the running mix is left untouched.
      if (start && state_q != IDLE) begin
        oOVERRUN <= 1'b1;
      end
    end
  end

  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Directed bench for audio_voice_mixer with hand-computed expected samples.
module tb_audio_voice_mixer;

  localparam int NV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic              rst_n;
  logic              lrck;
  logic [16*NV-1:0]  voice;
  logic [8*NV-1:0]   gain;
  logic [NV-1:0]     mute;
  logic              clip_clr;
  logic [15:0]       mix;
  logic              valid;
  logic              clip;
  logic              overrun;
  logic [1:0]        dbg_state;

  audio_voice_mixer #(.NUM_VOICES(NV)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iLRCK      (lrck),
    .iVOICE     (voice),
    .iGAIN      (gain),
    .iMUTE      (mute),
    .iCLIP_CLR  (clip_clr),
    .oMIX       (mix),
    .oVALID     (valid),
    .oCLIP      (clip),
    .oOVERRUN   (overrun),
    .oDBG_STATE (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks     = 0;
  int failures   = 0;
  int valid_cnt  = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_voices(input int v0, input int v1, input int v2, input int v3);
    voice = {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endtask

  task automatic set_gains(input int g0, input int g1, input int g2, input int g3);
    gain = {8'(g3), 8'(g2), 8'(g1), 8'(g0)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Raise LRCK, wait for the valid pulse and check latency, value and clip.
  // With corrupt set, the live voice inputs are rewritten mid-accumulation.
  task automatic run_mix(input string tag, input int exp_mix, input int exp_clip,
                         input bit corrupt);
    int  vc0;
    int  edges;
    bit  got;
    vc0   = valid_cnt;
    edges = -1;
    got   = 1'b0;
    lrck  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (corrupt && edges == 4) set_voices(5000, 5000, 5000, 5000);
      if (valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, edges, 7);
      check({tag, "_mix"}, $signed(mix), exp_mix);
      check({tag, "_clip"}, clip, exp_clip);
      tick();
      check({tag, "_valid_width"}, valid, 0);
      check({tag, "_hold"}, $signed(mix), exp_mix);
    end
    lrck = 1'b0;
    repeat (3) tick();
    check({tag, "_valid_count"}, valid_cnt - vc0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vc0;
    rst_n    = 1'b0;
    lrck     = 1'b0;
    voice    = '0;
    gain     = '0;
    mute     = '0;
    clip_clr = 1'b0;
    do_reset();

    check("rst_mix", $signed(mix), 0);
    check("rst_valid", valid, 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);

    // Unity single voice: 1000*128 >>> 7 = 1000.
    set_voices(1000, 0, 0, 0);
    set_gains(128, 0, 0, 0);
    mute = 4'b1110;
    run_mix("unity", 1000, 0, 1'b0);

    // Half gain: 1000*64 >>> 7 = 500.
    set_gains(64, 0, 0, 0);
    run_mix("half", 500, 0, 1'b0);

    // Floor rounding: -1*64 = -64, >>> 7 = -1.
    set_voices(-1, 0, 0, 0);
    run_mix("floor", -1, 0, 1'b0);

    // Positive clip: 4*32767*128 >>> 7 = 131068 -> 32767.
    set_voices(32767, 32767, 32767, 32767);
    set_gains(128, 128, 128, 128);
    mute = 4'b0000;
    run_mix("clip_pos", 32767, 1, 1'b0);

    // Negative clip: 4*(-20000) = -80000 -> -32768, clip stays sticky.
    set_voices(-20000, -20000, -20000, -20000);
    run_mix("clip_neg", -32768, 1, 1'b0);

    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_clear", clip, 0);

    // Mute voice 2 (300): 100+200+400 = 700, mid-mix input change ignored.
    set_voices(100, 200, 300, 400);
    mute = 4'b0100;
    run_mix("mute_snap", 700, 0, 1'b1);

    // Overrun: second LRCK rise lands while the first mix is accumulating.
    set_voices(100, 200, 300, 400);
    mute = 4'b0000;
    vc0  = valid_cnt;
    lrck = 1'b1;
    repeat (2) tick();
    lrck = 1'b0;
    repeat (2) tick();
    lrck = 1'b1;
    repeat (12) tick();
    check("ovr_flag", overrun, 1);
    check("ovr_mix", $signed(mix), 1000);
    check("ovr_valid_count", valid_cnt - vc0, 1);
    check("ovr_clip", clip, 0);
    lrck = 1'b0;
    repeat (3) tick();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("ovr_clear", overrun, 0);

    // Reset during ACCUM: no valid, outputs return to zero.
    set_voices(1000, 0, 0, 0);
    mute = 4'b1110;
    vc0  = valid_cnt;
    lrck = 1'b1;
    repeat (4) tick();
    check("mid_in_accum", dbg_state, 1);
    rst_n = 1'b0;
    lrck  = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_mix", $signed(mix), 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_clip", clip, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_state", dbg_state, 0);
    repeat (10) tick();
    check("mid_rst_no_valid", valid_cnt - vc0, 0);

    run_mix("after_rst", 1000, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
